raw_line_player: RTL and testbench
==================================

Name: raw_line_player

Overview:
Parametrised replay engine for raw multi-line captures (USB D+/D-, UART/MIDI lines), used in caravel DV benches.
- Accepts a byte stream from a file reader or memory model through a valid/ready handshake.
- Buffers bytes in a FIFO and replays them at a programmable sample rate onto CHANNELS lines.
- Drives each line only while the DUT releases it (oeb high), gated by an arm signal such as USB pull-up detect.

Parameters:
CHANNELS, 2, lines per sample; sample bit i drives line i; legal range 1..8.
FIFO_DEPTH, 16, buffer entries of 8 bits; power of 2, at least 4.
DIV_W, 8, width of the rate divider.
IDLE_VALUE, 0, CHANNELS-bit value driven when no sample is active.

Ports:
clk_samp  in  1  sample clock
RSTB  in  1  reset, synchronous, active-high
arm  in  1  enable playback (e.g. pull-up present)
rate_div  in  DIV_W  one sample every rate_div+1 cycles
in_data  in  8  capture byte
in_valid  in  1  in_data valid
in_last  in  1  in_data is final byte (qualified by in_valid)
in_ready  out  1  player accepts byte this cycle
line_oeb  in  CHANNELS  DUT oeb per line; 1 = DUT input
line_out  out  CHANNELS  value per line
line_drive_en  out  CHANNELS  tristate enable per line
sample_valid  out  1  line_out holds a replayed sample
done  out  1  stream fully replayed
underrun_cnt  out  16  saturating underrun count
fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
Reset values (RSTB=1 at a clk_samp edge):
- State IDLE; FIFO empty; fifo_level=0; in_ready=0.
- line_out=IDLE_VALUE; sample_valid=0; done=0; underrun_cnt=0; divider=0; last_seen=0.

Handshake:
- A byte is accepted when in_valid&&in_ready at a clock edge.
- in_ready = (state FILL or PLAY) && !full && !last_seen.
- Accepting a byte with in_last=1 sets last_seen.

Line drive:
- line_drive_en = line_oeb, combinational.
- line_out is registered and equals sample bits [CHANNELS-1:0]; upper byte bits are ignored.

States:
- IDLE: arm=1 -> FILL.
- FILL: accept bytes. Go to PLAY when FIFO full, or when last_seen and FIFO non-empty. If last_seen and FIFO empty -> DONE.
- PLAY: divider counts 0..rate_div.
  - When divider==rate_div: pop one byte; line_out<=byte; sample_valid<=1; divider<=0.
  - rate_div=0 gives one sample per cycle. The first pop occurs rate_div+1 cycles after entering PLAY.
  - Tick with FIFO empty and !last_seen = underrun: line_out<=IDLE_VALUE, sample_valid<=0, underrun_cnt+=1 (saturates at 16'hFFFF). Remain in PLAY.
  - Tick with FIFO empty and last_seen -> DONE.
- DONE: done=1; line_out=IDLE_VALUE; sample_valid=0; in_ready=0. Leave only via RSTB or arm=0 (-> IDLE).
- arm=0 in FILL/PLAY/DONE: next cycle IDLE, FIFO flushed, last_seen=0, done=0, line_out=IDLE_VALUE. underrun_cnt is retained; only RSTB clears it.

Boundaries:
- Push and pop in the same cycle: legal; level unchanged. A push while full is impossible (in_ready=0).
- rate_div changes mid-PLAY: take effect at the next divider compare.
- RSTB mid-stream: overrides everything, including accept/pop in that cycle.

Optional Feature:
RAW_LINE_PLAYER_HOLD_EN:
- Defined: an underrun holds the last replayed sample on line_out and keeps sample_valid=1. underrun_cnt still increments.
- Undefined: an underrun drives IDLE_VALUE with sample_valid=0, as specified above.

Test Plan:
1. Reset, arm=1, rate_div=0, stream 8'h01,8'h02,8'h03 (last on 8'h03) -> line_out 2'b01,2'b10,2'b11 on consecutive cycles, then done=1, line_out=2'b00.
2. rate_div=3, stream 4 bytes -> each sample held exactly 4 cycles; first sample 4 cycles after PLAY entry; fifo_level decrements 4 -> 0.
3. FIFO_DEPTH=16, source pauses after 16 bytes for 40 cycles, rate_div=0, no last -> underrun_cnt counts 1 per tick (24 after 40 cycles), line_out=IDLE_VALUE. With HOLD_EN: line_out holds byte 16's low bits.
4. line_oeb=2'b01 while playing -> line_drive_en=2'b01; toggling line_oeb mid-sample changes line_drive_en the same cycle, line_out unaffected.
5. arm dropped mid-PLAY with 5 bytes buffered -> next cycle IDLE, fifo_level=0, in_ready=0, underrun_cnt retained; re-arm replays fresh stream from first new byte.
6. CHANNELS=4, byte 8'hA5 -> line_out=4'h5; RSTB asserted during PLAY -> all outputs at reset values next edge.

Source files
------------

// File: rtl/raw_line_player.sv
// rtl/raw_line_player.sv - FIFO-buffered replay of captured bytes onto CHANNELS lines at a divided rate.
// Optional: define RAW_LINE_PLAYER_HOLD_EN to hold the last sample on line_out during an underrun.
module raw_line_player #(
   parameter int                  CHANNELS   = 2,
   parameter int                  FIFO_DEPTH = 16,
   parameter int                  DIV_W      = 8,
   parameter logic [CHANNELS-1:0] IDLE_VALUE = '0
) (
   input  logic                          clk_samp,
   input  logic                          RSTB,
   input  logic                          arm,
   input  logic [DIV_W-1:0]              rate_div,
   input  logic [7:0]                    in_data,
   input  logic                          in_valid,
   input  logic                          in_last,
   output logic                          in_ready,
   input  logic [CHANNELS-1:0]           line_oeb,
   output logic [CHANNELS-1:0]           line_out,
   output logic [CHANNELS-1:0]           line_drive_en,
   output logic                          sample_valid,
   output logic                          done,
   output logic [15:0]                   underrun_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_PLAY, S_DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [7:0]        mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [DIV_W-1:0]  divider;
   logic              last_seen;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              tick;
   logic [7:0]        head;

   assign full  = (fifo_level == (AW+1)'(FIFO_DEPTH));
   assign empty = (fifo_level == '0);
   // >= rather than == so a rate_div lowered below the running count still fires next cycle
   assign tick  = (state == S_PLAY) && (divider >= rate_div);
   assign push  = in_valid && in_ready;
   assign pop   = tick && !empty;
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk_samp) begin
      if (RSTB) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (arm) state_nxt = S_FILL;
         S_FILL: begin
            if (!arm)                          state_nxt = S_IDLE;
            else if (full)                     state_nxt = S_PLAY;
            else if (last_seen && !empty)      state_nxt = S_PLAY;
            else if (last_seen && empty)       state_nxt = S_DONE;
         end
         S_PLAY: begin
            if (!arm)                          state_nxt = S_IDLE;
            else if (tick && empty && last_seen) state_nxt = S_DONE;
         end
         S_DONE: if (!arm) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready      = ((state == S_FILL) || (state == S_PLAY)) && !full && !last_seen;
      done          = (state == S_DONE);
      line_drive_en = line_oeb;
   end

   always_ff @(posedge clk_samp) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk_samp) begin
      if (RSTB) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level   <= '0;
         last_seen    <= 1'b0;
         divider      <= '0;
         line_out     <= IDLE_VALUE;
         sample_valid <= 1'b0;
         underrun_cnt <= '0;
      end else if (!arm) begin
         // disarm flushes the stream but keeps the underrun history
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level   <= '0;
         last_seen    <= 1'b0;
         divider      <= '0;
         line_out     <= IDLE_VALUE;
         sample_valid <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (in_last) last_seen <= 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
            2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
            default: fifo_level <= fifo_level;
         endcase

         if (state == S_PLAY) begin
            divider <= tick ? '0 : divider + DIV_W'(1);
            if (tick) begin
               if (!empty) begin
                  line_out     <= CHANNELS'(head);
                  sample_valid <= 1'b1;
               end else if (!last_seen) begin
`ifdef RAW_LINE_PLAYER_HOLD_EN
                  line_out     <= line_out;
                  sample_valid <= sample_valid;
`else
                  line_out     <= IDLE_VALUE;
                  sample_valid <= 1'b0;
`endif
                  if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
               end else begin
                  line_out     <= IDLE_VALUE;
                  sample_valid <= 1'b0;
               end
            end
         end else begin
            divider <= '0;
         end
      end
   end

endmodule

// File: tb/tb_raw_line_player.sv
// tb/tb_raw_line_player.sv - scoreboard bench for raw_line_player (2- and 4-channel instances).
module tb_raw_line_player;

   logic        clk_samp = 1'b0;
   logic        RSTB;
   logic        arm;
   logic [7:0]  rate_div;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [1:0]  line_oeb;
   logic [1:0]  line_out;
   logic [1:0]  line_drive_en;
   logic        sample_valid;
   logic        done;
   logic [15:0] underrun_cnt;
   logic [4:0]  fifo_level;

   logic        in_ready4;
   logic [3:0]  line_oeb4;
   logic [3:0]  line_out4;
   logic [3:0]  line_drive_en4;
   logic        sample_valid4;
   logic        done4;
   logic [15:0] underrun_cnt4;
   logic [4:0]  fifo_level4;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  exp_q[$];
   int          exp_underrun = 0;

   always #5 clk_samp = ~clk_samp;

   raw_line_player #(.CHANNELS(2), .FIFO_DEPTH(16), .DIV_W(8)) u_dut (
      .clk_samp(clk_samp), .RSTB(RSTB), .arm(arm), .rate_div(rate_div),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .line_oeb(line_oeb), .line_out(line_out), .line_drive_en(line_drive_en),
      .sample_valid(sample_valid), .done(done), .underrun_cnt(underrun_cnt),
      .fifo_level(fifo_level)
   );

   raw_line_player #(.CHANNELS(4), .FIFO_DEPTH(16), .DIV_W(8)) u_dut4 (
      .clk_samp(clk_samp), .RSTB(RSTB), .arm(arm), .rate_div(rate_div),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready4),
      .line_oeb(line_oeb4), .line_out(line_out4), .line_drive_en(line_drive_en4),
      .sample_valid(sample_valid4), .done(done4), .underrun_cnt(underrun_cnt4),
      .fifo_level(fifo_level4)
   );

   task automatic tick();
      @(posedge clk_samp);
      #1;
   endtask

   task automatic do_reset();
      RSTB = 1'b1; arm = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
      rate_div = 8'd0; line_oeb = 2'b00; line_oeb4 = 4'h0;
      tick(); tick();
      RSTB = 1'b0;
      exp_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last, output bit ok);
      in_data = b; in_valid = 1'b1; in_last = last; ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (in_ready) begin ok = 1'b1; break; end
         tick();
      end
      if (ok) tick();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({line_out, sample_valid, done, in_ready, fifo_level, underrun_cnt, line_out4, done4}
          !== {2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0, 4'h0, 1'b0}) begin
         failures++;
         $display("FAIL reset_state: got line=%h sv=%b done=%b rdy=%b lvl=%0d urun=%0d, want all zero",
                  line_out, sample_valid, done, in_ready, fifo_level, underrun_cnt);
      end
   endtask

   task automatic test_basic();
      logic [7:0] b;
      bit ok, all_ok;
      do_reset(); arm = 1'b1; rate_div = 8'd0; tick();
      all_ok = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         b = 8'(i);
         exp_q.push_back(b);
         send_byte(b, (i == 3), ok);
         all_ok &= ok;
      end
      checks++;
      if (!all_ok) begin failures++; $display("FAIL basic_handshake: got ok=%b, want 1", all_ok); end
      tick();
      checks++;
      if ({sample_valid, fifo_level, in_ready} !== {1'b0, 5'd3, 1'b0}) begin
         failures++;
         $display("FAIL basic_pre_play: got sv=%b lvl=%0d rdy=%b, want 0 3 0", sample_valid, fifo_level, in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         b = exp_q.pop_front();
         checks++;
         if ({sample_valid, line_out, line_out4} !== {1'b1, b[1:0], b[3:0]}) begin
            failures++;
            $display("FAIL basic_sample%0d: got sv=%b line=%h line4=%h, want 1 %h %h",
                     i, sample_valid, line_out, line_out4, b[1:0], b[3:0]);
         end
      end
      tick();
      checks++;
      if ({done, sample_valid, line_out, done4} !== {1'b1, 1'b0, 2'b00, 1'b1}) begin
         failures++;
         $display("FAIL basic_done: got done=%b sv=%b line=%h, want 1 0 0", done, sample_valid, line_out);
      end
   endtask

   task automatic test_rate_div();
      logic [7:0] bytes [4];
      logic [7:0] b;
      bit ok, all_ok;
      bytes[0] = 8'h4D; bytes[1] = 8'h86; bytes[2] = 8'hF3; bytes[3] = 8'h2E;
      do_reset(); arm = 1'b1; rate_div = 8'd3; tick();
      all_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(bytes[i]);
         send_byte(bytes[i], (i == 3), ok);
         all_ok &= ok;
      end
      checks++;
      if (!all_ok) begin failures++; $display("FAIL rate_handshake: got ok=%b, want 1", all_ok); end
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if ({sample_valid, fifo_level} !== {1'b0, 5'd4}) begin
         failures++;
         $display("FAIL rate_first_latency: got sv=%b lvl=%0d, want 0 4", sample_valid, fifo_level);
      end
      for (int k = 0; k < 4; k++) begin
         b = exp_q.pop_front();
         for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if ({sample_valid, line_out, line_out4, fifo_level} !== {1'b1, b[1:0], b[3:0], 5'(3 - k)}) begin
               failures++;
               $display("FAIL rate_hold s%0d c%0d: got sv=%b line=%h line4=%h lvl=%0d, want 1 %h %h %0d",
                        k, c, sample_valid, line_out, line_out4, fifo_level, b[1:0], b[3:0], 3 - k);
            end
         end
      end
      tick();
      checks++;
      if ({done, line_out} !== {1'b1, 2'b00}) begin
         failures++;
         $display("FAIL rate_done: got done=%b line=%h, want 1 0", done, line_out);
      end
   endtask

   task automatic test_underrun();
      logic [7:0] b;
      logic [7:0] last_b;
      logic [2:0] hold_exp;
      bit ok, all_ok;
      do_reset(); arm = 1'b1; rate_div = 8'd0; tick();
      all_ok = 1'b1;
      last_b = 8'h00;
      for (int i = 0; i < 16; i++) begin
         b = 8'(i * 37 + 5);
         last_b = b;
         exp_q.push_back(b);
         send_byte(b, 1'b0, ok);
         all_ok &= ok;
      end
      checks++;
      if ({all_ok, fifo_level, in_ready} !== {1'b1, 5'd16, 1'b0}) begin
         failures++;
         $display("FAIL underrun_fill: got ok=%b lvl=%0d rdy=%b, want 1 16 0", all_ok, fifo_level, in_ready);
      end
      tick();
      for (int i = 0; i < 16; i++) begin
         tick();
         b = exp_q.pop_front();
         checks++;
         if ({sample_valid, line_out} !== {1'b1, b[1:0]}) begin
            failures++;
            $display("FAIL underrun_sample%0d: got sv=%b line=%h, want 1 %h", i, sample_valid, line_out, b[1:0]);
         end
      end
`ifdef RAW_LINE_PLAYER_HOLD_EN
      hold_exp = {1'b1, last_b[1:0]};
`else
      hold_exp = 3'b000;
`endif
      tick();
      checks++;
      if ({underrun_cnt, sample_valid, line_out} !== {16'd1, hold_exp}) begin
         failures++;
         $display("FAIL underrun_first: got urun=%0d sv=%b line=%h, want 1 %b", underrun_cnt, sample_valid, line_out, hold_exp);
      end
      for (int i = 0; i < 23; i++) tick();
      checks++;
      if ({underrun_cnt, sample_valid, line_out} !== {16'd24, hold_exp}) begin
         failures++;
         $display("FAIL underrun_count: got urun=%0d sv=%b line=%h, want 24 %b", underrun_cnt, sample_valid, line_out, hold_exp);
      end
      exp_q.push_back(8'hC6);
      send_byte(8'hC6, 1'b1, ok);
      tick();
      b = exp_q.pop_front();
      checks++;
      if ({ok, sample_valid, line_out, underrun_cnt} !== {1'b1, 1'b1, b[1:0], 16'd25}) begin
         failures++;
         $display("FAIL underrun_resume: got ok=%b sv=%b line=%h urun=%0d, want 1 1 %h 25",
                  ok, sample_valid, line_out, underrun_cnt, b[1:0]);
      end
      exp_underrun = 25;
      tick();
      checks++;
      if ({done, line_out} !== {1'b1, 2'b00}) begin
         failures++;
         $display("FAIL underrun_done: got done=%b line=%h, want 1 0", done, line_out);
      end
   endtask

   task automatic test_arm_drop();
      logic [7:0] b;
      bit ok, all_ok;
      arm = 1'b0; tick();
      arm = 1'b1; tick();
      rate_div = 8'd20;
      all_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send_byte(8'(8'h11 + i), (i == 4), ok);
         all_ok &= ok;
      end
      tick();
      checks++;
      if ({all_ok, fifo_level, sample_valid} !== {1'b1, 5'd5, 1'b0}) begin
         failures++;
         $display("FAIL armdrop_buffered: got ok=%b lvl=%0d sv=%b, want 1 5 0", all_ok, fifo_level, sample_valid);
      end
      arm = 1'b0;
      tick();
      checks++;
      if ({fifo_level, in_ready, done, sample_valid, line_out, underrun_cnt}
          !== {5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 16'(exp_underrun)}) begin
         failures++;
         $display("FAIL armdrop_flush: got lvl=%0d rdy=%b done=%b sv=%b line=%h urun=%0d, want 0 0 0 0 0 %0d",
                  fifo_level, in_ready, done, sample_valid, line_out, underrun_cnt, exp_underrun);
      end
      arm = 1'b1; rate_div = 8'd0; tick();
      exp_q.push_back(8'h81); send_byte(8'h81, 1'b0, ok); all_ok = ok;
      exp_q.push_back(8'h42); send_byte(8'h42, 1'b1, ok); all_ok &= ok;
      tick();
      for (int i = 0; i < 2; i++) begin
         tick();
         b = exp_q.pop_front();
         checks++;
         if ({all_ok, sample_valid, line_out} !== {1'b1, 1'b1, b[1:0]}) begin
            failures++;
            $display("FAIL armdrop_replay%0d: got ok=%b sv=%b line=%h, want 1 1 %h", i, all_ok, sample_valid, line_out, b[1:0]);
         end
      end
      tick();
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL armdrop_done: got %b, want 1", done); end
   endtask

   task automatic test_oeb();
      logic [7:0] b;
      bit ok, all_ok;
      do_reset(); arm = 1'b1; rate_div = 8'd7; tick();
      exp_q.push_back(8'h02); send_byte(8'h02, 1'b0, ok); all_ok = ok;
      exp_q.push_back(8'h03); send_byte(8'h03, 1'b1, ok); all_ok &= ok;
      for (int i = 0; i < 9; i++) tick();
      b = exp_q.pop_front();
      checks++;
      if ({all_ok, sample_valid, line_out} !== {1'b1, 1'b1, b[1:0]}) begin
         failures++;
         $display("FAIL oeb_sample: got ok=%b sv=%b line=%h, want 1 1 %h", all_ok, sample_valid, line_out, b[1:0]);
      end
      line_oeb = 2'b01; line_oeb4 = 4'b0101;
      #1;
      checks++;
      if ({line_drive_en, line_drive_en4, line_out} !== {2'b01, 4'b0101, b[1:0]}) begin
         failures++;
         $display("FAIL oeb_01: got en=%b en4=%b line=%h, want 01 0101 %h", line_drive_en, line_drive_en4, line_out, b[1:0]);
      end
      line_oeb = 2'b10; line_oeb4 = 4'b1010;
      #1;
      checks++;
      if ({line_drive_en, line_drive_en4, line_out} !== {2'b10, 4'b1010, b[1:0]}) begin
         failures++;
         $display("FAIL oeb_toggle: got en=%b en4=%b line=%h, want 10 1010 %h", line_drive_en, line_drive_en4, line_out, b[1:0]);
      end
   endtask

   task automatic test_channels_reset();
      logic [7:0] b;
      bit ok, all_ok;
      do_reset(); arm = 1'b1; rate_div = 8'd0; tick();
      exp_q.push_back(8'hA5); send_byte(8'hA5, 1'b0, ok); all_ok = ok;
      exp_q.push_back(8'h3C); send_byte(8'h3C, 1'b0, ok); all_ok &= ok;
      exp_q.push_back(8'h77); send_byte(8'h77, 1'b1, ok); all_ok &= ok;
      tick(); tick();
      b = exp_q.pop_front();
      checks++;
      if ({all_ok, line_out4, line_out, sample_valid4} !== {1'b1, 4'h5, 2'b01, 1'b1}) begin
         failures++;
         $display("FAIL channels_a5: got ok=%b line4=%h line=%h sv4=%b, want 1 5 1 1 (byte %h)",
                  all_ok, line_out4, line_out, sample_valid4, b);
      end
      RSTB = 1'b1;
      tick();
      checks++;
      if ({line_out, sample_valid, done, in_ready, fifo_level, underrun_cnt, line_out4, fifo_level4}
          !== {2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0, 4'h0, 5'd0}) begin
         failures++;
         $display("FAIL midstream_reset: got line=%h sv=%b done=%b rdy=%b lvl=%0d urun=%0d line4=%h, want all zero",
                  line_out, sample_valid, done, in_ready, fifo_level, underrun_cnt, line_out4);
      end
      RSTB = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      RSTB = 1'b1; arm = 1'b0; rate_div = 8'd0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
      line_oeb = 2'b00; line_oeb4 = 4'h0;
      test_reset();
      test_basic();
      test_rate_div();
      test_underrun();
      test_arm_drop();
      test_oeb();
      test_channels_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
